// File: rtl/hazard_list_collector_pkg.sv
// Shared constants, box type and collector state for the hazard list collector
// and the downstream grid encoder.
package hazard_pkg;
  localparam int COORD_W     = 8;
  localparam int MAX_HAZARDS = 15;
  localparam int ROW_MAX     = 7;
  localparam int COL_MAX     = 25;
  localparam int LIST_DEPTH  = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t top;
    coord_t left;
    coord_t bottom;
    coord_t right;
  } box_t;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    PUBLISH
  } collector_state_t;

  function automatic logic [3:0] sat_inc4(input logic [3:0] value);
    return (value == 4'hF) ? value : value + 4'd1;
  endfunction
endpackage

// File: rtl/hazard_list_collector_if.sv
// Box stream in, published hazard list out; the collector uses the slave side,
// the producer/encoder pair the master side.
interface hazard_list_collector_if;
  import hazard_pkg::*;

  logic       in_valid;
  logic       in_ready;
  logic       in_sof;
  logic       in_eof;
  logic       in_null;
  coord_t     in_top;
  coord_t     in_left;
  coord_t     in_bottom;
  coord_t     in_right;

  logic       out_valid;
  logic [3:0] out_num_hazards;
  coord_t     out_top    [LIST_DEPTH];
  coord_t     out_left   [LIST_DEPTH];
  coord_t     out_bottom [LIST_DEPTH];
  coord_t     out_right  [LIST_DEPTH];
  logic       out_overflow;
  logic [3:0] out_rejected;

  modport master (
    output in_valid, in_sof, in_eof, in_null, in_top, in_left, in_bottom, in_right,
    input  in_ready,
    input  out_valid, out_num_hazards, out_top, out_left, out_bottom, out_right,
    input  out_overflow, out_rejected
  );

  modport slave (
    input  in_valid, in_sof, in_eof, in_null, in_top, in_left, in_bottom, in_right,
    output in_ready,
    output out_valid, out_num_hazards, out_top, out_left, out_bottom, out_right,
    output out_overflow, out_rejected
  );
endinterface

// File: rtl/hazard_list_collector_sanitize.sv
// Combinational box sanitiser: normalise or reject inverted boxes, reject
// off-grid boxes, clip to the grid. HAZARD_NORMALIZE_EN selects swap vs reject.
module hazard_box_sanitize
  import hazard_pkg::*;
(
  input  box_t box_raw,
  output box_t box_clean,
  output logic reject
);
  localparam coord_t ROW_LIM = coord_t'(ROW_MAX);
  localparam coord_t COL_LIM = coord_t'(COL_MAX);

  always_comb begin
    box_clean = box_raw;
    reject    = 1'b0;
`ifdef HAZARD_NORMALIZE_EN
    if (box_raw.top > box_raw.bottom) begin
      box_clean.top    = box_raw.bottom;
      box_clean.bottom = box_raw.top;
    end
    if (box_raw.left > box_raw.right) begin
      box_clean.left  = box_raw.right;
      box_clean.right = box_raw.left;
    end
`else
    if ((box_raw.top > box_raw.bottom) || (box_raw.left > box_raw.right)) begin
      reject = 1'b1;
    end
`endif
    // A box whose origin is already off-grid has nothing left after clipping.
    if ((box_clean.top > ROW_LIM) || (box_clean.left > COL_LIM)) begin
      reject = 1'b1;
    end
    if (box_clean.bottom > ROW_LIM) begin
      box_clean.bottom = ROW_LIM;
    end
    if (box_clean.right > COL_LIM) begin
      box_clean.right = COL_LIM;
    end
  end
endmodule

// File: rtl/hazard_list_collector.sv
// Frame-based hazard box collector with a double-buffered published list.
// Inverted-box handling is set by HAZARD_NORMALIZE_EN inside hazard_box_sanitize.
module hazard_list_collector
  import hazard_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  hazard_list_collector_if.slave  bus
);
  localparam logic [3:0] MAX_CNT = 4'(MAX_HAZARDS);

  collector_state_t state;
  collector_state_t state_next;

  logic       ready;
  logic       accept;
  logic       restart;
  logic       take;
  box_t       box_raw;
  box_t       box_clean;
  logic       box_reject;

  box_t       work_box [LIST_DEPTH];
  logic [3:0] work_count;
  logic       work_overflow;
  logic [3:0] work_rejected;
  logic [3:0] base_count;
  logic       base_overflow;
  logic [3:0] base_rejected;

  assign ready        = (state != PUBLISH);
  assign bus.in_ready = ready;
  assign accept       = bus.in_valid & ready;
  assign restart      = accept & bus.in_sof;
  // In IDLE only a start-of-frame beat carries a box; stray beats are dropped.
  assign take         = accept & ((state == COLLECT) | bus.in_sof);
  assign box_raw      = '{top: bus.in_top, left: bus.in_left,
                          bottom: bus.in_bottom, right: bus.in_right};

  hazard_box_sanitize u_sanitize (
    .box_raw   (box_raw),
    .box_clean (box_clean),
    .reject    (box_reject)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && bus.in_eof) begin
          state_next = PUBLISH;
        end else if (accept && bus.in_sof) begin
          state_next = COLLECT;
        end
      end
      COLLECT: begin
        if (accept && bus.in_eof) begin
          state_next = PUBLISH;
        end
      end
      PUBLISH: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    base_count    = work_count;
    base_overflow = work_overflow;
    base_rejected = work_rejected;
    if (restart) begin
      base_count    = '0;
      base_overflow = 1'b0;
      base_rejected = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      work_count    <= '0;
      work_overflow <= 1'b0;
      work_rejected <= '0;
      for (int i = 0; i < LIST_DEPTH; i++) begin
        work_box[i] <= '0;
      end
    end else if (state == PUBLISH) begin
      work_count    <= '0;
      work_overflow <= 1'b0;
      work_rejected <= '0;
    end else if (take) begin
      work_count    <= base_count;
      work_overflow <= base_overflow;
      work_rejected <= base_rejected;
      if (!bus.in_null) begin
        if (box_reject) begin
          work_rejected <= sat_inc4(base_rejected);
        end else if (base_count < MAX_CNT) begin
          work_box[base_count] <= box_clean;
          work_count           <= base_count + 4'd1;
        end else begin
          work_overflow <= 1'b1;
        end
      end
    end
  end

  // Published list only changes on the PUBLISH cycle; unused slots read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid       <= 1'b0;
      bus.out_num_hazards <= '0;
      bus.out_overflow    <= 1'b0;
      bus.out_rejected    <= '0;
      for (int i = 0; i < LIST_DEPTH; i++) begin
        bus.out_top[i]    <= '0;
        bus.out_left[i]   <= '0;
        bus.out_bottom[i] <= '0;
        bus.out_right[i]  <= '0;
      end
    end else begin
      bus.out_valid <= (state == PUBLISH);
      if (state == PUBLISH) begin
        bus.out_num_hazards <= work_count;
        bus.out_overflow    <= work_overflow;
        bus.out_rejected    <= work_rejected;
        for (int i = 0; i < LIST_DEPTH; i++) begin
          if (4'(i) < work_count) begin
            bus.out_top[i]    <= work_box[i].top;
            bus.out_left[i]   <= work_box[i].left;
            bus.out_bottom[i] <= work_box[i].bottom;
            bus.out_right[i]  <= work_box[i].right;
          end else begin
            bus.out_top[i]    <= '0;
            bus.out_left[i]   <= '0;
            bus.out_bottom[i] <= '0;
            bus.out_right[i]  <= '0;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_hazard_list_collector.sv
// Directed self-checking bench for hazard_list_collector; expected lists are
// hand-computed per scenario, honouring HAZARD_NORMALIZE_EN for inverted boxes.
module tb_hazard_list_collector;
  import hazard_pkg::*;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  hazard_list_collector_if bus ();

  hazard_list_collector dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] entry(input int i);
    return {bus.out_top[i], bus.out_left[i], bus.out_bottom[i], bus.out_right[i]};
  endfunction

  // Present one beat at the falling edge, wait for acceptance, then drop valid.
  task automatic drive_beat(input logic sof, input logic eof, input logic nul,
                            input logic [7:0] t, input logic [7:0] l,
                            input logic [7:0] b, input logic [7:0] r);
    int waits;
    waits = 0;
    @(negedge clk);
    while (!bus.in_ready && waits < 8) begin
      @(negedge clk);
      waits++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_fail++;
      $display("[TB] FAIL ready_timeout: in_ready=%0b after %0d cycles, required 1", bus.in_ready, waits);
    end
    bus.in_sof    = sof;
    bus.in_eof    = eof;
    bus.in_null   = nul;
    bus.in_top    = t;
    bus.in_left   = l;
    bus.in_bottom = b;
    bus.in_right  = r;
    bus.in_valid  = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid  = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_sof = 1'b0; bus.in_eof = 1'b0; bus.in_null = 1'b0;
    bus.in_top = '0; bus.in_left = '0; bus.in_bottom = '0; bus.in_right = '0;
    #12;
    @(negedge clk);
    rst = 1'b0;
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_num_hazards !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_out: valid=%0b num=%0d, required 0 0", bus.out_valid, bus.out_num_hazards);
    end
    n_cmp++;
    if (bus.out_overflow !== 1'b0 || bus.out_rejected !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL reset_flags: ovf=%0b rej=%0d, required 0 0", bus.out_overflow, bus.out_rejected);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_ready: got %0b, required 1", bus.in_ready);
    end
  endtask

  task automatic test_basic_frame();
    logic [31:0] exp_e [16];
    foreach (exp_e[i]) exp_e[i] = '0;
    exp_e[0] = {8'd0, 8'd0, 8'd1, 8'd2};
    exp_e[1] = {8'd2, 8'd3, 8'd3, 8'd5};
    exp_e[2] = {8'd6, 8'd18, 8'd7, 8'd25};
    drive_beat(1, 0, 0, 0, 0, 1, 2);
    drive_beat(0, 0, 0, 2, 3, 3, 5);
    drive_beat(0, 1, 0, 6, 18, 7, 25);
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL basic_publish_cycle: valid=%0b ready=%0b, required 0 0", bus.out_valid, bus.in_ready);
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL basic_pulse: valid=%0b ready=%0b, required 1 1", bus.out_valid, bus.in_ready);
    end
    n_cmp++;
    if (bus.out_num_hazards !== 4'd3 || bus.out_overflow !== 1'b0 || bus.out_rejected !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL basic_counts: num=%0d ovf=%0b rej=%0d, required 3 0 0",
               bus.out_num_hazards, bus.out_overflow, bus.out_rejected);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (entry(i) !== exp_e[i]) begin
        n_fail++;
        $display("[TB] FAIL basic_entry%0d: got %h, required %h", i, entry(i), exp_e[i]);
      end
    end
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b0 || bus.out_num_hazards !== 4'd3) begin
      n_fail++;
      $display("[TB] FAIL basic_hold: valid=%0b num=%0d, required 0 3", bus.out_valid, bus.out_num_hazards);
    end
  endtask

  task automatic test_empty_frame();
    drive_beat(1, 1, 1, 3, 3, 4, 4);
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_num_hazards !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL empty_pulse: valid=%0b num=%0d, required 1 0", bus.out_valid, bus.out_num_hazards);
    end
    for (int i = 0; i < 16; i++) begin
      n_cmp++;
      if (entry(i) !== 32'd0) begin
        n_fail++;
        $display("[TB] FAIL empty_entry%0d: got %h, required 0", i, entry(i));
      end
    end
  endtask

  task automatic test_clip_reject();
    drive_beat(1, 0, 0, 5, 20, 12, 40);
    drive_beat(0, 1, 0, 9, 0, 9, 3);
    step();
    n_cmp++;
    if (bus.out_num_hazards !== 4'd1 || bus.out_rejected !== 4'd1 || bus.out_overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL clip_counts: num=%0d rej=%0d ovf=%0b, required 1 1 0",
               bus.out_num_hazards, bus.out_rejected, bus.out_overflow);
    end
    n_cmp++;
    if (entry(0) !== {8'd5, 8'd20, 8'd7, 8'd25} || entry(1) !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL clip_entry: got %h %h, required 05140719 00000000", entry(0), entry(1));
    end
  endtask

  task automatic test_inverted();
    logic [3:0]  exp_num;
    logic [3:0]  exp_rej;
    logic [31:0] exp_e0;
`ifdef HAZARD_NORMALIZE_EN
    exp_num = 4'd1; exp_rej = 4'd0; exp_e0 = {8'd1, 8'd4, 8'd3, 8'd10};
`else
    exp_num = 4'd0; exp_rej = 4'd1; exp_e0 = 32'd0;
`endif
    drive_beat(1, 1, 0, 3, 10, 1, 4);
    step();
    n_cmp++;
    if (bus.out_num_hazards !== exp_num || bus.out_rejected !== exp_rej) begin
      n_fail++;
      $display("[TB] FAIL inverted_counts: num=%0d rej=%0d, required %0d %0d",
               bus.out_num_hazards, bus.out_rejected, exp_num, exp_rej);
    end
    n_cmp++;
    if (entry(0) !== exp_e0) begin
      n_fail++;
      $display("[TB] FAIL inverted_entry: got %h, required %h", entry(0), exp_e0);
    end
  endtask

  task automatic test_overflow();
    logic [31:0] exp_e;
    for (int i = 0; i < 17; i++) begin
      drive_beat(i == 0, i == 16, 0, 8'(i % 8), 8'(i), 8'(i % 8), 8'(i + 1));
    end
    step();
    n_cmp++;
    if (bus.out_num_hazards !== 4'd15 || bus.out_overflow !== 1'b1 || bus.out_rejected !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL overflow_counts: num=%0d ovf=%0b rej=%0d, required 15 1 0",
               bus.out_num_hazards, bus.out_overflow, bus.out_rejected);
    end
    for (int i = 0; i < 16; i++) begin
      exp_e = (i < 15) ? {8'(i % 8), 8'(i), 8'(i % 8), 8'(i + 1)} : 32'd0;
      n_cmp++;
      if (entry(i) !== exp_e) begin
        n_fail++;
        $display("[TB] FAIL overflow_entry%0d: got %h, required %h", i, entry(i), exp_e);
      end
    end
  endtask

  task automatic test_reject_saturate();
    for (int i = 0; i < 17; i++) begin
      drive_beat(i == 0, i == 16, 0, 9, 0, 9, 0);
    end
    step();
    n_cmp++;
    if (bus.out_num_hazards !== 4'd0 || bus.out_rejected !== 4'd15 || bus.out_overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL saturate_counts: num=%0d rej=%0d ovf=%0b, required 0 15 0",
               bus.out_num_hazards, bus.out_rejected, bus.out_overflow);
    end
  endtask

  task automatic test_restart();
    drive_beat(0, 0, 0, 1, 1, 2, 2);
    drive_beat(1, 0, 0, 0, 0, 0, 0);
    drive_beat(0, 0, 0, 1, 1, 1, 1);
    drive_beat(0, 0, 0, 9, 0, 9, 0);
    drive_beat(0, 0, 0, 2, 2, 2, 2);
    drive_beat(1, 0, 0, 4, 5, 6, 7);
    drive_beat(0, 1, 0, 7, 24, 7, 25);
    step();
    n_cmp++;
    if (bus.out_num_hazards !== 4'd2 || bus.out_rejected !== 4'd0 || bus.out_overflow !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL restart_counts: num=%0d rej=%0d ovf=%0b, required 2 0 0",
               bus.out_num_hazards, bus.out_rejected, bus.out_overflow);
    end
    n_cmp++;
    if (entry(0) !== {8'd4, 8'd5, 8'd6, 8'd7} || entry(1) !== {8'd7, 8'd24, 8'd7, 8'd25}
        || entry(2) !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL restart_entries: got %h %h %h, required 04050607 07180719 00000000",
               entry(0), entry(1), entry(2));
    end
  endtask

  task automatic test_reset_midframe();
    logic seen_valid;
    drive_beat(1, 0, 0, 1, 2, 3, 4);
    drive_beat(0, 0, 0, 2, 2, 3, 3);
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.out_num_hazards !== 4'd0 || entry(0) !== 32'd0 || entry(1) !== 32'd0
        || bus.out_valid !== 1'b0 || bus.out_overflow !== 1'b0 || bus.out_rejected !== 4'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_outputs: num=%0d e0=%h e1=%h valid=%0b, required all 0",
               bus.out_num_hazards, entry(0), entry(1), bus.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      seen_valid = seen_valid | bus.out_valid;
    end
    n_cmp++;
    if (seen_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL midreset_quiet: pulse=%0b ready=%0b, required 0 1", seen_valid, bus.in_ready);
    end
    // An eof without sof after reset must publish an empty list: the partial frame is gone.
    drive_beat(0, 1, 0, 3, 3, 3, 3);
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_num_hazards !== 4'd0 || entry(0) !== 32'd0) begin
      n_fail++;
      $display("[TB] FAIL midreset_lost: valid=%0b num=%0d e0=%h, required 1 0 0",
               bus.out_valid, bus.out_num_hazards, entry(0));
    end
  endtask

  task automatic test_back_to_back();
    drive_beat(1, 1, 0, 1, 1, 2, 2);
    drive_beat(1, 1, 0, 3, 6, 4, 9);
    step();
    n_cmp++;
    if (bus.out_valid !== 1'b1 || bus.out_num_hazards !== 4'd1 || entry(0) !== {8'd3, 8'd6, 8'd4, 8'd9}) begin
      n_fail++;
      $display("[TB] FAIL back_to_back: valid=%0b num=%0d e0=%h, required 1 1 03060409",
               bus.out_valid, bus.out_num_hazards, entry(0));
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_basic_frame();
    test_empty_frame();
    test_clip_reject();
    test_inverted();
    test_overflow();
    test_reject_saturate();
    test_restart();
    test_reset_midframe();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_list_collector.md
# hazard_list_collector

Frame-based collector that sits directly upstream of the hazard grid encoder. It accepts hazard bounding boxes one beat at a time over a valid/ready stream and sanitises each box against the 8-row × 26-column grid, rejecting or clipping it as required. At end of frame it publishes a stable, double-buffered hazard list (count plus top/left/bottom/right arrays) that the encoder consumes combinationally.

## Interface
- `MAX_HAZARDS`, default 15: hazards stored per frame; capped by the 4-bit count.
- `ROW_MAX`, default 7: largest valid row coordinate.
- `COL_MAX`, default 25: largest valid column coordinate (six 3-wide columns plus two 4-wide columns).

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  beat valid.
- `in_ready`  out  1  collector can accept a beat.
- `in_sof`  in  1  beat starts a frame.
- `in_eof`  in  1  beat ends a frame.
- `in_null`  in  1  marker-only beat; box fields ignored.
- `in_top`, `in_left`, `in_bottom`, `in_right`  in  8 each  box coordinates.
- `out_valid`  out  1  one-cycle pulse: new list published.
- `out_num_hazards`  out  4  stored box count.
- `out_top`, `out_left`, `out_bottom`, `out_right`  out  8 × [0:15] each  published boxes.
- `out_overflow`  out  1  frame had more than `MAX_HAZARDS` accepted boxes.
- `out_rejected`  out  4  boxes rejected in the frame, saturating at 15.

## Operation
- **States:**
  - `IDLE`: `in_ready`=1. Beats without `in_sof` are accepted and discarded.
  - `COLLECT`: `in_ready`=1.
  - `PUBLISH`: `in_ready`=0; lasts one cycle.
- **Transitions:**
  - `IDLE` to `COLLECT` on an accepted `in_sof` beat without `in_eof`.
  - `IDLE` or `COLLECT` to `PUBLISH` on an accepted `in_eof` beat. A beat with both `in_sof` and `in_eof` is a complete single-beat frame.
  - `PUBLISH` to `IDLE` unconditionally.
- **`in_sof` while in `COLLECT`:** restarts the frame. The working count, overflow flag and rejected count clear, and that beat's box counts as the new frame's first box.
- **Box processing** applies to every accepted beat with `in_null`=0, in this order:
  - Normalise, or reject when the box is inverted (see Configuration).
  - Reject if `top`>`ROW_MAX` or `left`>`COL_MAX`, i.e. fully off-grid.
  - Clip `bottom` to `ROW_MAX` and `right` to `COL_MAX`.
  - If the working count is below `MAX_HAZARDS`, store the box at index count and increment the count. Otherwise drop it and set overflow.
  - A rejected box increments the rejected count, saturating at 15. Rejected boxes never set overflow.
- **Publish:** copy the working entries to the output registers. Entries at index ≥ count are driven to 0. Entry 15 is always 0.
- **Hold:** outputs stay stable until the next publish. The downstream encoder samples them whenever it needs to.

## Timing
- A beat transfers on a rising edge with `in_valid`&`in_ready`. Data may change freely while `in_ready`=0.
- Latency: if the `in_eof` beat is accepted at edge N, `PUBLISH` occupies cycle N+1. Outputs update at edge N+1, and `out_valid` is high for that one cycle, then low. `in_ready` returns high after edge N+1.
- Maximum throughput is one box per cycle. There is one bubble per frame.
- Reset (asynchronous, any state, including mid-frame):
  - State goes to `IDLE`.
  - All outputs go to 0 (`out_valid`, `out_num_hazards`, all arrays, `out_overflow`, `out_rejected`).
  - `in_ready`=1 once `rst` is released.
  - The partial frame is lost.

## Configuration
- `HAZARD_NORMALIZE_EN` defined: if `top`>`bottom`, the two are swapped; likewise if `left`>`right`. The box then continues through the rejection and clipping steps.
- `HAZARD_NORMALIZE_EN` undefined: a box with `top`>`bottom` or `left`>`right` is rejected.

## Structure
- Package `hazard_pkg` holds:
  - `COORD_W`=8, `MAX_HAZARDS`, `ROW_MAX`, `COL_MAX`.
  - `coord_t` (8-bit).
  - A `box_t` struct with `top`/`left`/`bottom`/`right`.
  - The collector state enum.
  
  The grid encoder shares the same constants.
- Sub-module `hazard_box_sanitize` is combinational. It takes `box_t` in and produces a sanitised `box_t` plus a reject flag. It contains the normalisation, rejection and clipping logic.

## Test plan
- **Basic frame:** three beats, (0,0,1,2) with sof, then (2,3,3,5), then (6,18,7,25) with eof.
  - `out_valid` pulses one cycle after eof is accepted.
  - num=3 and the three entries match exactly; entries 3..15 are 0.
  - overflow=0, rejected=0.
- **Empty frame:** one beat with sof=eof=null=1 → `out_valid` pulse, num=0, all entries 0.
- **Overflow:** 17 valid boxes in one frame → num=15, the first 15 boxes are kept, overflow=1.
- **Clip and reject:** box (5,20,12,40) and box (9,0,9,3) → stored (5,20,7,25), num=1, rejected=1.
- **Inverted box:** (3,10,1,4) → with `HAZARD_NORMALIZE_EN`, stored (1,4,3,10); without it, num=0, rejected=1.
- **Restart and reset:**
  - sof arriving mid-frame after 4 boxes, then 2 more boxes with eof → num=2, and only the post-restart boxes are present.
  - Assert `rst` mid-frame → all outputs 0 immediately and no `out_valid` pulse.
